present_round_ctrl: RTL

- Iterative PRESENT block-cipher encryption controller. Sequences one round datapath through 31 rounds plus a final key whitening.
- The datapath is addRoundKey, sLayer built from present_sbox instances, pLayer, and the key schedule.
- The 16 state nibbles time-share SBOX_PAR present_sbox instances, trading throughput for area.
- Sits between a valid/ready plaintext source and a valid/ready ciphertext sink.

---
 rtl/present_round_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT encryption controller: one shared round datapath, SBOX_PAR state S-boxes.
// Build option: define PRESENT_KEY128_EN for the PRESENT-128 key schedule (default PRESENT-80).

module present_sbox (
  input  logic [3:0] nib_i,
  output logic [3:0] sub_c
);
  always_comb begin
    sub_c = 4'h0;
    case (nib_i)
      4'h0: sub_c = 4'hC;
      4'h1: sub_c = 4'h5;
      4'h2: sub_c = 4'h6;
      4'h3: sub_c = 4'hB;
      4'h4: sub_c = 4'h9;
      4'h5: sub_c = 4'h0;
      4'h6: sub_c = 4'hA;
      4'h7: sub_c = 4'hD;
      4'h8: sub_c = 4'h3;
      4'h9: sub_c = 4'hE;
      4'hA: sub_c = 4'hF;
      4'hB: sub_c = 4'h8;
      4'hC: sub_c = 4'h4;
      4'hD: sub_c = 4'h7;
      4'hE: sub_c = 4'h1;
      4'hF: sub_c = 4'h2;
      default: sub_c = 4'h0;
    endcase
  end
endmodule

module present_round_ctrl #(
  parameter int unsigned SBOX_PAR = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  idat,
  input  logic [127:0] ikey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  odat
);

  localparam int unsigned K       = 16 / SBOX_PAR;
  localparam int unsigned CW      = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SLICE_W = SBOX_PAR * 4;
`ifdef PRESENT_KEY128_EN
  localparam int unsigned KW = 128;
`else
  localparam int unsigned KW = 80;
`endif

  if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 ||
        SBOX_PAR == 8 || SBOX_PAR == 16)) begin : g_bad_par
    $error("present_round_ctrl: SBOX_PAR must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SUB, S_PERM, S_FIN, S_DONE
  } fsm_e;

  fsm_e              fsm_q;
  logic [63:0]       state_q;
  logic [KW-1:0]     key_q;
  logic [4:0]        round_q;
  logic [CW-1:0]     cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [63:0]       odat_q;

  logic [63:0]       rkey;
  logic [SLICE_W-1:0] slice_in;
  logic [SLICE_W-1:0] slice_out;
  logic [63:0]       sub_state;
  logic [63:0]       perm_state;
  logic [KW-1:0]     key_rot;
  logic [KW-1:0]     key_next;

  assign rkey = key_q[KW-1 -: 64];

  // Select the nibble group handled this SUB cycle
  always_comb begin
    slice_in = '0;
    for (int unsigned c = 0; c < K; c++) begin
      if (cnt_q == CW'(c)) slice_in = state_q[c*SLICE_W +: SLICE_W];
    end
  end

  for (genvar j = 0; j < SBOX_PAR; j++) begin : g_sbox
    present_sbox u_sbox (
      .nib_i (slice_in[4*j +: 4]),
      .sub_c (slice_out[4*j +: 4])
    );
  end

  always_comb begin
    sub_state = state_q;
    for (int unsigned c = 0; c < K; c++) begin
      if (cnt_q == CW'(c)) sub_state[c*SLICE_W +: SLICE_W] = slice_out;
    end
  end

  // pLayer: bit i -> (16*i) mod 63, bit 63 stays put
  always_comb begin
    perm_state     = state_q;
    perm_state[63] = state_q[63];
    for (int unsigned i = 0; i < 63; i++) begin
      perm_state[(16*i) % 63] = state_q[i];
    end
  end

`ifdef PRESENT_KEY128_EN
  logic [3:0] ks_hi;
  logic [3:0] ks_lo;

  assign key_rot = {key_q[66:0], key_q[127:67]};

  present_sbox u_ksbox_hi (.nib_i(key_rot[127:124]), .sub_c(ks_hi));
  present_sbox u_ksbox_lo (.nib_i(key_rot[123:120]), .sub_c(ks_lo));

  always_comb begin
    key_next          = key_rot;
    key_next[127:124] = ks_hi;
    key_next[123:120] = ks_lo;
    key_next[66:62]   = key_rot[66:62] ^ round_q;
  end
`else
  logic [3:0] ks_hi;
  logic       unused_ikey_hi;

  assign key_rot        = {key_q[18:0], key_q[79:19]};
  assign unused_ikey_hi = ^ikey[127:80];

  present_sbox u_ksbox_hi (.nib_i(key_rot[79:76]), .sub_c(ks_hi));

  always_comb begin
    key_next        = key_rot;
    key_next[79:76] = ks_hi;
    key_next[19:15] = key_rot[19:15] ^ round_q;
  end
`endif

  // Round sequencer: ADD, K x SUB, PERM per round; FIN applies the last whitening key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= 5'd1;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      odat_q      <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= idat;
            key_q      <= ikey[KW-1:0];
            round_q    <= 5'd1;
            in_ready_q <= 1'b0;
            fsm_q      <= S_ADD;
          end
        end
        S_ADD: begin
          state_q <= state_q ^ rkey;
          cnt_q   <= '0;
          fsm_q   <= S_SUB;
        end
        S_SUB: begin
          state_q <= sub_state;
          if (cnt_q == CW'(K - 1)) begin
            cnt_q <= '0;
            fsm_q <= S_PERM;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PERM: begin
          state_q <= perm_state;
          key_q   <= key_next;
          if (round_q == 5'd31) begin
            fsm_q <= S_FIN;
          end else begin
            round_q <= round_q + 5'd1;
            fsm_q   <= S_ADD;
          end
        end
        S_FIN: begin
          odat_q      <= state_q ^ rkey;
          out_valid_q <= 1'b1;
          fsm_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          fsm_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign odat      = odat_q;

endmodule
